// File: rtl/reset_sequencer.sv
// Ordered release / reverse shutdown of up to eight active-low peripheral reset domains,
// with per-stage hold-off delays and a level fault that drops every stage at once.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned DELAY_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              peripheral_aresetn,
    input  logic [NUM_STAGES*DELAY_WIDTH-1:0] cfg_delay,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              fault,
    input  logic                              clear,
    output logic [NUM_STAGES-1:0]             stage_aresetn,
    output logic                              busy,
    output logic                              done,
    output logic [31:0]                       sts
);

    localparam int unsigned NS    = NUM_STAGES;
    localparam int unsigned DW    = DELAY_WIDTH;
    localparam int unsigned PTR_W = 3;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_SHUTDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic [NS-1:0]    stage_q, stage_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      sts_q, sts_d;

    logic [PTR_W-1:0] ptr_inc_c;
    logic [PTR_W-1:0] ptr_dec_c;
    logic [NS-1:0]    stage_bit_c;
    logic [DW-1:0]    dly_first_c;
    logic [DW-1:0]    dly_next_c;

    assign ptr_inc_c   = ptr_q + PTR_W'(1);
    assign ptr_dec_c   = ptr_q - PTR_W'(1);
    assign stage_bit_c = NS'(1) << ptr_q;
    assign dly_first_c = cfg_delay[DW-1:0];

    // Delay of the stage that follows the current pointer.
    always_comb begin
        dly_next_c = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (ptr_inc_c == PTR_W'(k)) begin
                dly_next_c = cfg_delay[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sts_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sts_q   <= sts_d;
        end
    end

    // Next-state logic; fault overrides everything, then stop, then start.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;

        if (fault) begin
            state_d = ST_FAULT;
            stage_d = '0;
            ptr_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stage_d = '0;
                    if (start && !stop) begin
                        state_d = ST_RELEASE;
                        ptr_d   = '0;
                        cnt_d   = dly_first_c;
                    end
                end
                ST_RELEASE: begin
                    if (stop) begin
                        cnt_d = '0;
                        // ptr counts released stages, so ptr==0 means nothing is out of reset yet
                        if (ptr_q == '0) begin
                            state_d = ST_IDLE;
                            stage_d = '0;
                        end else begin
                            state_d = ST_SHUTDOWN;
                            ptr_d   = ptr_dec_c;
                        end
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - DW'(1);
                    end else begin
                        stage_d = stage_q | stage_bit_c;
                        if (ptr_q == LAST_PTR) begin
                            state_d = ST_RUNNING;
                        end else begin
                            ptr_d = ptr_inc_c;
                            cnt_d = dly_next_c;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (stop) begin
                        state_d = ST_SHUTDOWN;
                        ptr_d   = LAST_PTR;
                    end
                end
                ST_SHUTDOWN: begin
                    stage_d = stage_q & ~stage_bit_c;
                    if (ptr_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d = ptr_dec_c;
                    end
                end
                ST_FAULT: begin
                    if (clear) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            endcase
        end
    end

    // Status outputs are registered alongside the state they describe.
    always_comb begin
        busy_d          = (state_d == ST_RELEASE) || (state_d == ST_SHUTDOWN);
        done_d          = (state_d == ST_RUNNING);
        sts_d           = '0;
        sts_d[2:0]      = state_d;
        sts_d[6:4]      = ptr_d;
        sts_d[8 +: NS]  = stage_d;
        sts_d[16]       = fault;
    end

    assign stage_aresetn = stage_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sts           = sts_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release timing, shutdown, abort, fault, ignored requests, async reset.
module tb_reset_sequencer;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 16;

    logic             clk;
    logic             rst_n;
    logic [NS*DW-1:0] cfg_delay;
    logic             start, stop, fault, clear;
    logic [NS-1:0]    stage_aresetn;
    logic             busy, done;
    logic [31:0]      sts;

    int passed;
    int total;

    logic [3:0] rel_stage [0:13];

    reset_sequencer #(.NUM_STAGES(NS), .DELAY_WIDTH(DW)) dut (
        .clk                (clk),
        .peripheral_aresetn (rst_n),
        .cfg_delay          (cfg_delay),
        .start              (start),
        .stop               (stop),
        .fault              (fault),
        .clear              (clear),
        .stage_aresetn      (stage_aresetn),
        .busy               (busy),
        .done               (done),
        .sts                (sts)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Start pulse with delays {3,0,5,1}; stages rise 4, 5, 11, 13 edges after the start edge.
    task automatic release_run(input string pfx);
        start = 1'b1;
        step();
        start = 1'b0;
        check({pfx, "_start_sts"}, sts, 32'h0000_0001);
        check({pfx, "_start_busy"}, 32'(busy), 32'd1);
        for (int r = 1; r <= 13; r++) begin
            step();
            check($sformatf("%s_stage_r%0d", pfx, r), 32'(stage_aresetn), 32'(rel_stage[r]));
            check($sformatf("%s_busy_r%0d", pfx, r), 32'(busy), (r < 13) ? 32'd1 : 32'd0);
            check($sformatf("%s_done_r%0d", pfx, r), 32'(done), (r == 13) ? 32'd1 : 32'd0);
        end
        check({pfx, "_running_sts"}, sts, 32'h0000_0F32);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rel_stage = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h3,
                      4'h3, 4'h3, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        fault = 1'b0;
        clear = 1'b0;
        cfg_delay = {16'd1, 16'd5, 16'd0, 16'd3};

        step();
        step();
        check("rst_stage", 32'(stage_aresetn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sts", sts, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_sts", sts, 32'd0);

        release_run("rel1");

        // start while running is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        check("run_start_ign_sts", sts, 32'h0000_0F32);
        check("run_start_ign_done", 32'(done), 32'd1);

        // Reverse shutdown
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("sd_t0_stage", 32'(stage_aresetn), 32'hF);
        check("sd_t0_sts", sts, 32'h0000_0F33);
        step();
        check("sd_t1_stage", 32'(stage_aresetn), 32'h7);
        step();
        check("sd_t2_stage", 32'(stage_aresetn), 32'h3);
        step();
        check("sd_t3_stage", 32'(stage_aresetn), 32'h1);
        check("sd_t3_busy", 32'(busy), 32'd1);
        step();
        check("sd_t4_stage", 32'(stage_aresetn), 32'h0);
        check("sd_t4_sts", sts, 32'd0);
        check("sd_t4_done", 32'(done), 32'd0);
        check("sd_t4_busy", 32'(busy), 32'd0);

        // Abort mid-release with delays {0,0,100,0}
        cfg_delay = {16'd0, 16'd100, 16'd0, 16'd0};
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("ab_r1_stage", 32'(stage_aresetn), 32'h1);
        step();
        check("ab_r2_stage", 32'(stage_aresetn), 32'h3);
        for (int i = 3; i <= 9; i++) step();
        check("ab_r9_sts", sts, 32'h0000_0321);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("ab_r10_sts", sts, 32'h0000_0313);
        step();
        check("ab_r11_stage", 32'(stage_aresetn), 32'h1);
        step();
        check("ab_r12_stage", 32'(stage_aresetn), 32'h0);
        check("ab_r12_sts", sts, 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("ab_after_stage", 32'(stage_aresetn), 32'h0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_idle_sts", sts, 32'd0);
        check("ss_idle_busy", 32'(busy), 32'd0);

        // Fault during release, same edge as stop
        cfg_delay = {16'd1, 16'd5, 16'd0, 16'd3};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) step();
        check("flt_pre_stage", 32'(stage_aresetn), 32'h3);
        fault = 1'b1;
        stop  = 1'b1;
        step();
        stop = 1'b0;
        check("flt_stage", 32'(stage_aresetn), 32'h0);
        check("flt_sts", sts, 32'h0001_0004);
        check("flt_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("flt_start_ign", sts, 32'h0001_0004);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("flt_clear_ign", sts, 32'h0001_0004);
        fault = 1'b0;
        step();
        check("flt_low_held", sts, 32'h0000_0004);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("flt_clear_sts", sts, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("flt_restart_sts", sts, 32'h0000_0001);

        // Async reset between edges while releasing
        for (int i = 1; i <= 5; i++) step();
        check("ar_pre_stage", 32'(stage_aresetn), 32'h3);
        rst_n = 1'b0;
        #1;
        check("ar_stage", 32'(stage_aresetn), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_sts", sts, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("ar_post_sts", sts, 32'd0);
        release_run("rel2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
